pe_rs: RTL and testbench

Parametrised row-stationary processing element for the Eyeriss array, successor to the single-MAC PE. It holds one filter row in a local weight scratchpad, slides a window over a streamed image row, and for each window position adds a full 1-D dot product to an incoming partial sum from the PE above. All three streams use valid/ready handshakes. A bypass mode forwards partial sums unchanged for idle columns.

---
 rtl/pe_pkg.sv | 32 +++
 rtl/pe_spad.sv | 28 ++
 rtl/pe_rs.sv | 209 ++++++++++++++++++++
 tb/tb_pe_rs.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and arithmetic helpers for the row-stationary processing element.
package pe_pkg;

    localparam int unsigned ACT_W_DEF  = 16;
    localparam int unsigned WGT_W_DEF  = 16;
    localparam int unsigned PSUM_W_DEF = 32;
    localparam int unsigned S_MAX_DEF  = 4;

    // Widest operand/accumulator the MAC helper handles; callers truncate to PSUM_W.
    localparam int unsigned MAC_OP_W  = 32;
    localparam int unsigned MAC_ACC_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_FILL,
        ST_WAIT_PSUM,
        ST_MAC,
        ST_OUT,
        ST_BYPASS
    } pe_state_t;

    // Signed multiply-accumulate; the low PSUM_W bits of the result wrap correctly.
    function automatic logic signed [MAC_ACC_W-1:0] mac(
        input logic signed [MAC_ACC_W-1:0] acc,
        input logic signed [MAC_OP_W-1:0]  a,
        input logic signed [MAC_OP_W-1:0]  w
    );
        return acc + (MAC_ACC_W'(a) * MAC_ACC_W'(w));
    endfunction

endpackage

// File: rtl/pe_spad.sv
// Small register-file scratchpad: synchronous write, asynchronous read.
module pe_spad #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned W     = 16,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem <= '{default: '0};
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pe_rs.sv
// Row-stationary PE: holds one filter row, slides a window over an activation row,
// and adds each 1-D dot product to an upstream partial sum. Bypass forwards psums.
module pe_rs
    import pe_pkg::*;
#(
    parameter  int unsigned ACT_W  = ACT_W_DEF,
    parameter  int unsigned WGT_W  = WGT_W_DEF,
    parameter  int unsigned PSUM_W = PSUM_W_DEF,
    parameter  int unsigned S_MAX  = S_MAX_DEF,
    localparam int unsigned LEN_W  = $clog2(S_MAX + 1),
    localparam int unsigned IDX_W  = (S_MAX > 1) ? $clog2(S_MAX) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cfg_start,
    input  logic [LEN_W-1:0]  i_cfg_len,
    input  logic              i_cfg_bypass,
    input  logic              i_w_valid,
    output logic              o_w_ready,
    input  logic [WGT_W-1:0]  i_w_data,
    input  logic              i_act_valid,
    output logic              o_act_ready,
    input  logic [ACT_W-1:0]  i_act_data,
    input  logic              i_act_last,
    input  logic              i_psum_in_valid,
    output logic              o_psum_in_ready,
    input  logic [PSUM_W-1:0] i_psum_in,
    output logic              o_psum_out_valid,
    input  logic              i_psum_out_ready,
    output logic [PSUM_W-1:0] o_psum_out,
    output logic              o_busy,
    output logic              o_done
);

    pe_state_t                r_state;
    logic [LEN_W-1:0]         r_len;
    logic [LEN_W-1:0]         r_cnt;
    logic [IDX_W-1:0]         r_idx;
    logic [IDX_W-1:0]         r_k;
    logic                     r_last;
    logic                     r_w_ready;
    logic                     r_act_ready;
    logic                     r_psin_ready;
    logic                     r_pout_valid;
    logic [PSUM_W-1:0]        r_pout;
    logic                     r_done;
    logic signed [PSUM_W-1:0] r_acc;
    logic signed [ACT_W-1:0]  r_win [S_MAX];

    logic [LEN_W-1:0]         w_cfg_len;
    logic [LEN_W-1:0]         w_len_m1;
    logic [LEN_W-1:0]         w_cnt_inc;
    logic [IDX_W-1:0]         w_last_idx;
    logic                     w_bypass;
    logic                     w_act_hs;
    logic                     w_w_hs;
    logic [WGT_W-1:0]         w_wgt_raw;
    logic signed [WGT_W-1:0]  w_wgt_k;
    logic signed [PSUM_W-1:0] w_acc_next;
    logic signed [ACT_W-1:0]  w_win_shift [S_MAX];

    // Out-of-range filter lengths fall back to the full scratchpad depth.
    assign w_cfg_len  = (i_cfg_len == '0 || i_cfg_len > LEN_W'(S_MAX)) ? LEN_W'(S_MAX) : i_cfg_len;
    assign w_len_m1   = r_len - LEN_W'(1);
    assign w_cnt_inc  = r_cnt + LEN_W'(1);
    assign w_last_idx = IDX_W'(w_len_m1);
    assign w_bypass   = (r_state == ST_BYPASS);
    assign w_act_hs   = r_act_ready & i_act_valid;
    assign w_w_hs     = r_w_ready & i_w_valid;

    pe_spad #(
        .DEPTH (S_MAX),
        .W     (WGT_W)
    ) u_wspad (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_w_hs),
        .i_waddr (r_idx),
        .i_wdata (i_w_data),
        .i_raddr (r_k),
        .o_rdata (w_wgt_raw)
    );

    assign w_wgt_k    = $signed(w_wgt_raw);
    assign w_acc_next = PSUM_W'(mac(MAC_ACC_W'(r_acc), MAC_OP_W'(r_win[r_k]), MAC_OP_W'(w_wgt_k)));

    // Window shift: entries below S-1 move down one, newest lands at S-1.
    for (genvar g = 0; g < S_MAX; g++) begin : g_win
        if (g < S_MAX - 1) begin : g_mid
            assign w_win_shift[g] = (LEN_W'(g) == w_len_m1) ? $signed(i_act_data) :
                                    (LEN_W'(g) <  w_len_m1) ? r_win[g + 1] : r_win[g];
        end else begin : g_top
            assign w_win_shift[g] = (LEN_W'(g) == w_len_m1) ? $signed(i_act_data) : r_win[g];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_k          <= '0;
            r_last       <= 1'b0;
            r_w_ready    <= 1'b0;
            r_act_ready  <= 1'b0;
            r_psin_ready <= 1'b0;
            r_pout_valid <= 1'b0;
            r_pout       <= '0;
            r_done       <= 1'b0;
            r_acc        <= '0;
            r_win        <= '{default: '0};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_cfg_start) begin
                        r_len  <= w_cfg_len;
                        r_cnt  <= '0;
                        r_idx  <= '0;
                        r_last <= 1'b0;
                        if (i_cfg_bypass) begin
                            r_state     <= ST_BYPASS;
                            r_act_ready <= 1'b1;
                        end else begin
                            r_state   <= ST_LOAD_W;
                            r_w_ready <= 1'b1;
                        end
                    end
                end
                ST_LOAD_W: begin
                    if (w_w_hs) begin
                        r_idx <= r_idx + IDX_W'(1);
                        if (r_idx == w_last_idx) begin
                            r_state     <= ST_FILL;
                            r_w_ready   <= 1'b0;
                            r_act_ready <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (w_act_hs) begin
                        r_win  <= w_win_shift;
                        r_cnt  <= w_cnt_inc;
                        r_last <= r_last | i_act_last;
                        if (w_cnt_inc == r_len) begin
                            r_state      <= ST_WAIT_PSUM;
                            r_act_ready  <= 1'b0;
                            r_psin_ready <= 1'b1;
                        end else if (r_last | i_act_last) begin
                            // Row too short for even one window.
                            r_state     <= ST_IDLE;
                            r_act_ready <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                ST_WAIT_PSUM: begin
                    if (i_psum_in_valid) begin
                        r_acc        <= $signed(i_psum_in);
                        r_k          <= '0;
                        r_state      <= ST_MAC;
                        r_psin_ready <= 1'b0;
                    end
                end
                ST_MAC: begin
                    r_acc <= w_acc_next;
                    r_k   <= r_k + IDX_W'(1);
                    if (r_k == w_last_idx) begin
                        r_state      <= ST_OUT;
                        r_pout       <= w_acc_next;
                        r_pout_valid <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (i_psum_out_ready) begin
                        r_pout_valid <= 1'b0;
                        if (r_last) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= ST_FILL;
                            r_cnt       <= w_len_m1;
                            r_act_ready <= 1'b1;
                        end
                    end
                end
                ST_BYPASS: begin
                    if (i_act_valid && i_act_last) begin
                        r_state     <= ST_IDLE;
                        r_act_ready <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Bypass is a pure combinational pass-through of the psum channel.
    assign o_psum_out       = w_bypass ? i_psum_in        : r_pout;
    assign o_psum_out_valid = w_bypass ? i_psum_in_valid  : r_pout_valid;
    assign o_psum_in_ready  = w_bypass ? i_psum_out_ready : r_psin_ready;
    assign o_w_ready        = r_w_ready;
    assign o_act_ready      = r_act_ready;
    assign o_busy           = (r_state != ST_IDLE);
    assign o_done           = r_done;

endmodule

// File: tb/tb_pe_rs.sv
// Randomized bench for pe_rs against a sliding-window dot-product reference model.
module tb_pe_rs;

    localparam int TMO = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_cfg_start;
    logic [2:0]  i_cfg_len;
    logic        i_cfg_bypass;
    logic        i_w_valid;
    logic        o_w_ready;
    logic [15:0] i_w_data;
    logic        i_act_valid;
    logic        o_act_ready;
    logic [15:0] i_act_data;
    logic        i_act_last;
    logic        i_psum_in_valid;
    logic        o_psum_in_ready;
    logic [31:0] i_psum_in;
    logic        o_psum_out_valid;
    logic        i_psum_out_ready;
    logic [31:0] o_psum_out;
    logic        o_busy;
    logic        o_done;

    int          n_chk = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          out_cnt = 0;
    int          w_q[$];
    int          a_q[$];
    int          p_q[$];
    logic [31:0] exp_q[$];

    pe_rs dut (
        .clk              (clk),
        .rst              (rst),
        .i_cfg_start      (i_cfg_start),
        .i_cfg_len        (i_cfg_len),
        .i_cfg_bypass     (i_cfg_bypass),
        .i_w_valid        (i_w_valid),
        .o_w_ready        (o_w_ready),
        .i_w_data         (i_w_data),
        .i_act_valid      (i_act_valid),
        .o_act_ready      (o_act_ready),
        .i_act_data       (i_act_data),
        .i_act_last       (i_act_last),
        .i_psum_in_valid  (i_psum_in_valid),
        .o_psum_in_ready  (o_psum_in_ready),
        .i_psum_in        (i_psum_in),
        .o_psum_out_valid (o_psum_out_valid),
        .i_psum_out_ready (i_psum_out_ready),
        .o_psum_out       (o_psum_out),
        .o_busy           (o_busy),
        .o_done           (o_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        #1;
        if (o_done === 1'b1) done_cnt++;
        if (o_psum_out_valid === 1'b1 && i_psum_out_ready === 1'b1) out_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h (%0d) expected=%0h (%0d) t=%0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // Output j = psum[j] + sum_k act[j+k]*w[k], wrapped to 32 bits.
    task automatic build_expected(input int s);
        longint acc;
        exp_q.delete();
        for (int j = 0; j + s <= a_q.size(); j++) begin
            acc = longint'(p_q[j]);
            for (int k = 0; k < s; k++) acc += longint'(a_q[j + k]) * longint'(w_q[k]);
            exp_q.push_back(32'(acc));
        end
    endtask

    task automatic idle_inputs();
        i_cfg_start = 0; i_cfg_len = 0; i_cfg_bypass = 0;
        i_w_valid = 0; i_w_data = 0;
        i_act_valid = 0; i_act_data = 0; i_act_last = 0;
        i_psum_in_valid = 0; i_psum_in = 0; i_psum_out_ready = 0;
    endtask

    task automatic start(input int len, input bit byp);
        @(negedge clk);
        i_cfg_start = 1; i_cfg_len = 3'(len); i_cfg_bypass = byp;
        @(negedge clk);
        i_cfg_start = 0;
        #1 chk("busy_after_start", 32'(o_busy), 32'd1);
    endtask

    task automatic send_weights(input int s);
        bit hs;
        int t;
        for (int i = 0; i < s; i++) begin
            hs = 0; t = 0;
            repeat ($urandom_range(0, 1)) begin @(negedge clk); i_w_valid = 0; end
            while (!hs && t < TMO) begin
                @(negedge clk); i_w_valid = 1; i_w_data = 16'(w_q[i]);
                #1 hs = o_w_ready; t++;
            end
            if (!hs) chk("w_timeout", 32'd0, 32'd1);
        end
        @(negedge clk); i_w_valid = 0;
    endtask

    task automatic send_acts(input bit with_last);
        bit hs;
        int t;
        for (int i = 0; i < a_q.size(); i++) begin
            hs = 0; t = 0;
            repeat ($urandom_range(0, 2)) begin @(negedge clk); i_act_valid = 0; end
            while (!hs && t < TMO) begin
                @(negedge clk);
                i_act_valid = 1; i_act_data = 16'(a_q[i]);
                i_act_last = with_last && (i == a_q.size() - 1);
                #1 hs = o_act_ready; t++;
            end
            if (!hs) chk("act_timeout", 32'd0, 32'd1);
        end
        @(negedge clk); i_act_valid = 0; i_act_last = 0;
    endtask

    task automatic send_psums();
        bit hs;
        int t;
        for (int i = 0; i < p_q.size(); i++) begin
            hs = 0; t = 0;
            repeat ($urandom_range(0, 2)) begin @(negedge clk); i_psum_in_valid = 0; end
            while (!hs && t < TMO) begin
                @(negedge clk); i_psum_in_valid = 1; i_psum_in = 32'(p_q[i]);
                #1 hs = o_psum_in_ready; t++;
            end
            if (!hs) chk("psum_in_timeout", 32'd0, 32'd1);
        end
        @(negedge clk); i_psum_in_valid = 0;
    endtask

    // hold < 0: random ready; otherwise stall each output for 'hold' valid cycles.
    task automatic recv_outs(input int hold);
        bit hs;
        int t;
        int vcnt;
        logic [31:0] held;
        for (int i = 0; i < exp_q.size(); i++) begin
            hs = 0; t = 0; vcnt = 0; held = 0;
            while (!hs && t < TMO) begin
                @(negedge clk);
                i_psum_out_ready = (hold >= 0) ? (vcnt >= hold) : ($urandom_range(0, 3) != 0);
                #1;
                if (o_psum_out_valid) begin
                    if (vcnt > 0) chk("out_stable", o_psum_out, held);
                    if (hold >= 0 && !i_psum_out_ready) begin
                        chk("bp_act_ready", 32'(o_act_ready), 32'd0);
                        chk("bp_psin_ready", 32'(o_psum_in_ready), 32'd0);
                    end
                    held = o_psum_out; vcnt++; hs = i_psum_out_ready;
                end
                t++;
            end
            if (!hs) chk("out_timeout", 32'd0, 32'd1);
            else chk("psum_out", o_psum_out, exp_q[i]);
        end
        @(negedge clk); i_psum_out_ready = 0;
    endtask

    task automatic run_row(input int len_cfg, input int hold);
        int s;
        int d0;
        int o0;
        s = (len_cfg == 0 || len_cfg > 4) ? 4 : len_cfg;
        d0 = done_cnt; o0 = out_cnt;
        build_expected(s);
        start(len_cfg, 1'b0);
        fork
            send_weights(s);
            send_acts(1'b1);
            send_psums();
            recv_outs(hold);
        join
        repeat (3) @(negedge clk);
        #1;
        chk("out_count", 32'(out_cnt - o0), 32'(exp_q.size()));
        chk("done_count", 32'(done_cnt - d0), 32'd1);
        chk("idle_after_row", 32'(o_busy), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_w_ready"}, 32'(o_w_ready), 32'd0);
        chk({tag, "_act_ready"}, 32'(o_act_ready), 32'd0);
        chk({tag, "_psin_ready"}, 32'(o_psum_in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(o_psum_out_valid), 32'd0);
        chk({tag, "_psum_out"}, o_psum_out, 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
    endtask

    initial begin
        int len;
        int n;
        int s;
        int d0;
        int byp_vals[3];

        idle_inputs();
        rst = 1;
        @(negedge clk); #1;
        check_outputs_zero("reset");
        @(negedge clk); rst = 0;

        // Basic sliding window
        w_q = '{1, 2, 3}; a_q = '{1, 2, 3, 4, 5}; p_q = '{10, 10, 10};
        run_row(3, -1);

        // Signed product and wrap-around
        w_q = '{-2}; a_q = '{7}; p_q = '{5};
        run_row(1, -1);
        w_q = '{1}; a_q = '{1}; p_q = '{32'h7FFF_FFFF};
        run_row(1, -1);

        // Backpressure
        w_q = '{2, 3}; a_q = '{3, 4, 5}; p_q = '{0, 100};
        run_row(2, 5);

        // Short row: no output possible
        w_q = '{1, 2, 3, 4}; a_q = '{5, 6}; p_q = {};
        run_row(4, -1);

        // Bypass
        d0 = done_cnt;
        byp_vals = '{100, 200, 300};
        start(0, 1'b1);
        foreach (byp_vals[i]) begin
            @(negedge clk);
            i_psum_in_valid = 1; i_psum_in = 32'(byp_vals[i]); i_psum_out_ready = 1;
            #1;
            chk("byp_data", o_psum_out, 32'(byp_vals[i]));
            chk("byp_valid", 32'(o_psum_out_valid), 32'd1);
            chk("byp_ready", 32'(o_psum_in_ready), 32'd1);
        end
        @(negedge clk); i_psum_out_ready = 0; #1;
        chk("byp_ready_bp", 32'(o_psum_in_ready), 32'd0);
        chk("byp_act_ready", 32'(o_act_ready), 32'd1);
        @(negedge clk); i_psum_in_valid = 0; i_act_valid = 1; i_act_data = 16'd9; i_act_last = 1;
        @(negedge clk); i_act_valid = 0; i_act_last = 0; #1;
        chk("byp_done", 32'(o_done), 32'd1);
        @(negedge clk); #1;
        chk("byp_idle", 32'(o_busy), 32'd0);
        chk("byp_done_count", 32'(done_cnt - d0), 32'd1);

        // Reset during MAC
        d0 = done_cnt;
        w_q = '{1, 2, 3, 4}; a_q = '{1, 1, 1, 1}; p_q = '{5};
        start(4, 1'b0);
        fork
            send_weights(4);
            send_acts(1'b0);
            send_psums();
        join
        rst = 1; #1;
        check_outputs_zero("mid_reset");
        @(negedge clk); rst = 0;
        repeat (2) @(negedge clk);
        #1 chk("mid_reset_no_done", 32'(done_cnt - d0), 32'd0);
        w_q = '{3, -1, 2, 5}; a_q = '{4, 7, -3, 2, 9}; p_q = '{1000, -50};
        run_row(4, -1);

        // Randomized rows, including out-of-range lengths
        for (int r = 0; r < 20; r++) begin
            len = $urandom_range(0, 7);
            s = (len == 0 || len > 4) ? 4 : len;
            n = $urandom_range(1, 8);
            w_q.delete(); a_q.delete(); p_q.delete();
            for (int i = 0; i < s; i++) w_q.push_back(int'($urandom_range(0, 65535)) - 32768);
            for (int i = 0; i < n; i++) a_q.push_back(int'($urandom_range(0, 65535)) - 32768);
            for (int i = 0; i + s <= n; i++) p_q.push_back(int'($urandom));
            run_row(len, ($urandom_range(0, 3) == 0) ? 2 : -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
